// File: rtl/program_loader.sv
// program_loader: boot-time loader that parses a byte stream and drives the
// processor load interface (instruction words first, then data words), then
// raises start_signal.
//
// Stream (big-endian): N[15:0], M[15:0], N instruction words, M data words,
// and, when LOADER_CHECKSUM_EN is defined, one trailing XOR byte covering
// every preceding byte.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   rx_data/valid/ready byte input handshake (transfer on valid && ready)
//   new_instruction    assembled word, valid with load_strobe, held after
//   load_strobe        one-cycle write pulse
//   add_into           0 = instruction memory, 1 = data memory
//   start_signal       sticky, begin execution
//   error              sticky, load aborted
//   loaded_count       words strobed so far (saturating)
//
// Optional feature macro: LOADER_CHECKSUM_EN
module program_loader #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] new_instruction,
    output logic        load_strobe,
    output logic        add_into,
    output logic        start_signal,
    output logic        error,
    output logic [15:0] loaded_count
);

    typedef enum logic [2:0] {
        S_HDR,
        S_INSTR,
        S_SWITCH,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RUN,
        S_ERROR
    } state_t;

    state_t      state, state_nx;
    logic [23:0] shreg;       // last three accepted bytes
    logic [1:0]  byte_cnt;    // byte position within the current 4-byte group
    logic [15:0] n_words, m_words, word_cnt;
    logic        strobe_nx;
    logic        accept, word_done;
    logic [15:0] hdr_n, hdr_m;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Gating with reset keeps the handshake closed while reset is asserted.
    assign rx_ready = reset && (state == S_HDR || state == S_INSTR ||
`ifdef LOADER_CHECKSUM_EN
                                state == S_CHK ||
`endif
                                state == S_DATA);
    assign accept    = rx_valid && rx_ready;
    assign word_done = accept && (byte_cnt == 2'd3);
    assign hdr_n     = shreg[23:8];
    assign hdr_m     = {shreg[7:0], rx_data};

    always_comb begin
        state_nx  = state;
        strobe_nx = 1'b0;
        case (state)
            S_HDR: begin
                if (word_done) begin
                    if (hdr_n == 16'd0 ||
                        {16'd0, hdr_n} > 32'(IMEM_DEPTH) ||
                        {16'd0, hdr_m} > 32'(DMEM_DEPTH))
                        state_nx = S_ERROR;
                    else
                        state_nx = S_INSTR;
                end
            end
            S_INSTR: begin
                if (word_done) begin
                    strobe_nx = 1'b1;
                    if (word_cnt == n_words - 16'd1) state_nx = S_SWITCH;
                end
            end
            S_SWITCH: begin
                if (m_words != 16'd0)
                    state_nx = S_DATA;
                else
`ifdef LOADER_CHECKSUM_EN
                    state_nx = S_CHK;
`else
                    state_nx = S_RUN;
`endif
            end
            S_DATA: begin
                if (word_done) begin
                    strobe_nx = 1'b1;
                    if (word_cnt == m_words - 16'd1)
`ifdef LOADER_CHECKSUM_EN
                        state_nx = S_CHK;
`else
                        state_nx = S_RUN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_nx = (csum == rx_data) ? S_RUN : S_ERROR;
            end
`endif
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_HDR;
            shreg           <= '0;
            byte_cnt        <= '0;
            n_words         <= '0;
            m_words         <= '0;
            word_cnt        <= '0;
            new_instruction <= '0;
            load_strobe     <= 1'b0;
            add_into        <= 1'b0;
            start_signal    <= 1'b0;
            error           <= 1'b0;
            loaded_count    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum            <= '0;
`endif
        end else begin
            state       <= state_nx;
            load_strobe <= strobe_nx;
            if (accept) begin
                shreg    <= {shreg[15:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
            end
            if (state == S_HDR && word_done) begin
                n_words <= hdr_n;
                m_words <= hdr_m;
            end
            if (strobe_nx) begin
                new_instruction <= {shreg, rx_data};
                word_cnt        <= word_cnt + 16'd1;
                if (loaded_count != 16'hFFFF) loaded_count <= loaded_count + 16'd1;
            end
            if (state == S_SWITCH) begin
                add_into <= 1'b1;
                word_cnt <= '0;
            end
            error <= error || (state_nx == S_ERROR);
            // Entering RUN on the edge that also launches the final strobe
            // delays start by one cycle so it never overlaps a strobe.
            start_signal <= start_signal || (state == S_RUN) ||
                            (state_nx == S_RUN && !strobe_nx);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] new_instruction;
    logic        load_strobe;
    logic        add_into;
    logic        start_signal;
    logic        error;
    logic [15:0] loaded_count;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .new_instruction(new_instruction),
        .load_strobe(load_strobe), .add_into(add_into),
        .start_signal(start_signal), .error(error),
        .loaded_count(loaded_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Monitor: records every strobe and the first rise of the flags.
    int          cyc = 0;
    int          s_cyc[$];
    logic [31:0] s_word[$];
    logic        s_add[$];
    int          add_rise, start_rise, late;

    task automatic clr_mon();
        s_cyc.delete(); s_word.delete(); s_add.delete();
        add_rise = -1; start_rise = -1; late = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (add_into && add_rise < 0) add_rise = cyc;
        if (start_signal && start_rise < 0) start_rise = cyc;
        if (load_strobe) begin
            s_cyc.push_back(cyc);
            s_word.push_back(new_instruction);
            s_add.push_back(add_into);
            if (start_rise >= 0) late++;
        end
    end

    // All drives happen 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_outputs", {new_instruction, load_strobe, add_into, start_signal, error}, 0);
        chk("rst_count", loaded_count, 0);
        reset = 1'b1;
        clr_mon();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 0;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (rx_ready) got = 1;
            @(posedge clk); #1;
        end
        if (!got) chk("accept_timeout", 0, 1);
        rx_valid = 1'b0;
    endtask

    logic [31:0] nominal_w [3] = '{32'h04350004, 32'h04360005, 32'h0000000A};

    task automatic run_load(input int n, input int m, input bit nominal,
                            input bit bad_csum, input int maxgap, input bit midreset);
        logic [7:0]  bytes[$];
        logic [31:0] exp_w[$];
        logic        exp_a[$];
        logic [7:0]  cs;
        logic [31:0] w;
        bit          hdr_bad, exp_err;
        int          mingap;
        logic [15:0] cnt_before;

        hdr_bad = (n == 0) || (n > 1024) || (m > 1024);
        bytes.push_back(8'(n >> 8)); bytes.push_back(8'(n));
        bytes.push_back(8'(m >> 8)); bytes.push_back(8'(m));
        exp_err = hdr_bad;
        if (!hdr_bad) begin
            for (int i = 0; i < n + m; i++) begin
                w = nominal ? nominal_w[i] : $urandom;
                exp_w.push_back(w);
                exp_a.push_back(i >= n);
                for (int k = 3; k >= 0; k--) bytes.push_back(8'(w >> (8 * k)));
            end
`ifdef LOADER_CHECKSUM_EN
            cs = 8'h00;
            foreach (bytes[i]) cs ^= bytes[i];
            bytes.push_back(bad_csum ? (cs ^ 8'h10) : cs);
            exp_err = bad_csum;
`endif
        end

        do_reset();
        if (midreset) begin
            for (int i = 0; i < 6; i++) send_byte(bytes[i], 0);
            do_reset();
        end
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(maxgap, 0));
        repeat (8) begin @(posedge clk); #1; end

        chk("n_strobes", s_word.size(), exp_w.size());
        for (int i = 0; i < s_word.size() && i < exp_w.size(); i++) begin
            chk($sformatf("word%0d", i), s_word[i], exp_w[i]);
            chk($sformatf("add%0d", i), s_add[i], exp_a[i]);
        end
        chk("loaded_count", loaded_count, exp_w.size());
        chk("start", start_signal, !exp_err);
        chk("error", error, exp_err);
        chk("rx_ready_term", rx_ready, 0);
        chk("late_strobe", late, 0);
        chk("add_final", add_into, !hdr_bad);
        if (s_cyc.size() > 1) begin
            mingap = 1000;
            for (int i = 1; i < s_cyc.size(); i++)
                if (s_cyc[i] - s_cyc[i-1] < mingap) mingap = s_cyc[i] - s_cyc[i-1];
            chk("strobe_gap_ge4", mingap >= 4, 1);
        end
        if (!hdr_bad && s_cyc.size() == n + m) begin
            chk("add_rise", add_rise, s_cyc[n-1] + 1);
`ifndef LOADER_CHECKSUM_EN
            chk("start_rise", start_rise, s_cyc[s_cyc.size()-1] + 1);
`endif
        end

        // Terminal state must refuse further bytes.
        cnt_before = loaded_count;
        rx_valid = 1'b1; rx_data = 8'hA5;
        repeat (3) begin @(negedge clk); chk("term_no_ready", rx_ready, 0); end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("term_count", loaded_count, cnt_before);
    endtask

    initial begin
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        clr_mon();
        repeat (2) begin @(posedge clk); #1; end

        run_load(2, 1, 1, 0, 0, 0);       // nominal, no gaps
        run_load(2, 1, 1, 0, 5, 0);       // nominal with stalls
        run_load(2, 1, 1, 0, 0, 1);       // reset mid-word, then nominal
        run_load(1, 0, 0, 0, 2, 0);       // zero data words
        run_load(0, 1, 0, 0, 0, 0);       // N == 0
        run_load(1025, 0, 0, 0, 0, 0);    // N too large
        run_load(1, 1025, 0, 0, 0, 0);    // M too large
        run_load(1024, 0, 0, 0, 0, 0);    // N at the depth limit
`ifdef LOADER_CHECKSUM_EN
        run_load(2, 1, 1, 1, 0, 0);       // corrupted checksum
`endif
        for (int r = 0; r < 6; r++)
            run_load($urandom_range(6, 1), $urandom_range(4, 0), 0, 0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
